// File: rtl/dm_arb_pkg.sv
// Shared types for the data-memory access arbiter: FSM encoding, port ids and the byte-lane mask helper.
package dm_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_BRG = 1'b1;

    function automatic logic [31:0] be_mask(input logic [3:0] be);
        logic [31:0] mask;
        mask = '0;
        for (int i = 0; i < 4; i++) begin
            mask[i*8 +: 8] = {8{be[i]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/dm_arb_pick.sv
// Grant selection between the CPU and bridge requesters.
// DM_ARB_ROUND_ROBIN_EN selects round-robin on contention; otherwise the CPU port has fixed priority.
module dm_arb_pick
    import dm_arb_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic rr_last,
    output logic id,
    output logic valid
);

    assign valid = req0 | req1;

`ifdef DM_ARB_ROUND_ROBIN_EN
    // On contention the port that did not win last time gets the grant.
    always_comb begin
        id = PORT_CPU;
        if (req0 && req1) begin
            id = ~rr_last;
        end else if (req1) begin
            id = PORT_BRG;
        end
    end
`else
    logic unused_rr_last;
    assign unused_rr_last = rr_last;

    always_comb begin
        id = PORT_CPU;
        if (!req0 && req1) begin
            id = PORT_BRG;
        end
    end
`endif

endmodule

// File: rtl/dm_access_arbiter.sv
// Serialises CPU and bridge accesses to a single-port word memory; partial stores become read-modify-write.
// Build option: DM_ARB_ROUND_ROBIN_EN enables round-robin arbitration (default: port 0 fixed priority).
module dm_access_arbiter
    import dm_arb_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req0,
    input  logic            req1,
    input  logic            we0,
    input  logic            we1,
    input  logic [AW-1:0]   addr0,
    input  logic [AW-1:0]   addr1,
    input  logic [DW-1:0]   wdata0,
    input  logic [DW-1:0]   wdata1,
    input  logic [DW/8-1:0] be0,
    input  logic [DW/8-1:0] be1,
    input  logic [31:0]     pc0,
    input  logic [31:0]     pc1,
    output logic            ack0,
    output logic            ack1,
    output logic [DW-1:0]   rdata0,
    output logic [DW-1:0]   rdata1,
    output logic [AW-1:0]   m_addr,
    output logic [DW-1:0]   m_wd,
    output logic            m_we,
    output logic [31:0]     m_pc,
    input  logic [DW-1:0]   m_rd,
    output logic            busy
);

    localparam int BW = DW / 8;

    state_t          state_reg;
    logic            id_reg;
    logic            we_reg;
    logic [DW-1:0]   wdata_reg;
    logic [BW-1:0]   be_reg;
    logic [AW-1:0]   m_addr_reg;
    logic [31:0]     m_pc_reg;
    logic            m_we_reg;
    logic [DW-1:0]   buf_reg;
    logic            ack0_reg;
    logic            ack1_reg;
    logic [DW-1:0]   rdata0_reg;
    logic [DW-1:0]   rdata1_reg;
    logic            rr_last;

    logic            pick_id;
    logic            pick_valid;
    logic [DW-1:0]   lane_mask;
    logic [DW-1:0]   merged_next;

`ifdef DM_ARB_ROUND_ROBIN_EN
    logic rr_last_reg;
    assign rr_last = rr_last_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_last_reg <= 1'b1;
        end else if (state_reg == ST_IDLE && pick_valid) begin
            rr_last_reg <= pick_id;
        end
    end
`else
    assign rr_last = 1'b1;
`endif

    dm_arb_pick u_pick (
        .req0    (req0),
        .req1    (req1),
        .rr_last (rr_last),
        .id      (pick_id),
        .valid   (pick_valid)
    );

    generate
        for (genvar gi = 0; gi < BW; gi++) begin : g_lane
            assign lane_mask[gi*8 +: 8] = {8{be_reg[gi]}};
        end
    endgenerate

    // Loads pass the memory word through; stores overlay the enabled lanes.
    assign merged_next = we_reg ? ((m_rd & ~lane_mask) | (wdata_reg & lane_mask)) : m_rd;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg  <= ST_IDLE;
            id_reg     <= PORT_CPU;
            we_reg     <= 1'b0;
            wdata_reg  <= '0;
            be_reg     <= '0;
            m_addr_reg <= '0;
            m_pc_reg   <= '0;
            m_we_reg   <= 1'b0;
            buf_reg    <= '0;
            ack0_reg   <= 1'b0;
            ack1_reg   <= 1'b0;
            rdata0_reg <= '0;
            rdata1_reg <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (pick_valid) begin
                        id_reg     <= pick_id;
                        we_reg     <= pick_id ? we1    : we0;
                        wdata_reg  <= pick_id ? wdata1 : wdata0;
                        be_reg     <= pick_id ? be1    : be0;
                        m_addr_reg <= pick_id ? addr1  : addr0;
                        m_pc_reg   <= pick_id ? pc1    : pc0;
                        state_reg  <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    buf_reg <= merged_next;
                    if (we_reg && be_reg != '0) begin
                        m_we_reg  <= 1'b1;
                        state_reg <= ST_WRITE;
                    end else begin
                        // ack/rdata are registered, so they are loaded on entry to DONE.
                        if (id_reg == PORT_BRG) begin
                            ack1_reg   <= 1'b1;
                            rdata1_reg <= merged_next;
                        end else begin
                            ack0_reg   <= 1'b1;
                            rdata0_reg <= merged_next;
                        end
                        state_reg <= ST_DONE;
                    end
                end
                ST_WRITE: begin
                    m_we_reg <= 1'b0;
                    if (id_reg == PORT_BRG) begin
                        ack1_reg   <= 1'b1;
                        rdata1_reg <= buf_reg;
                    end else begin
                        ack0_reg   <= 1'b1;
                        rdata0_reg <= buf_reg;
                    end
                    state_reg <= ST_DONE;
                end
                default: begin
                    ack0_reg  <= 1'b0;
                    ack1_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign ack0   = ack0_reg;
    assign ack1   = ack1_reg;
    assign rdata0 = rdata0_reg;
    assign rdata1 = rdata1_reg;
    assign m_addr = m_addr_reg;
    assign m_wd   = buf_reg;
    assign m_we   = m_we_reg;
    assign m_pc   = m_pc_reg;
    assign busy   = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_dm_access_arbiter.sv
// Directed-vector bench for dm_access_arbiter with a behavioural word memory on the memory side.
module tb_dm_access_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic        we0 = 1'b0, we1 = 1'b0;
    logic [31:0] addr0 = '0, addr1 = '0;
    logic [31:0] wdata0 = '0, wdata1 = '0;
    logic [3:0]  be0 = '0, be1 = '0;
    logic [31:0] pc0 = 32'h0000_1000, pc1 = 32'h0000_2000;
    logic        ack0, ack1;
    logic [31:0] rdata0, rdata1;
    logic [31:0] m_addr, m_wd, m_pc, m_rd;
    logic        m_we, busy;

    logic [31:0] mem [0:1023];
    logic        pre_en = 1'b0;
    logic [9:0]  pre_idx = '0;
    logic [31:0] pre_val = '0;
    int          write_cnt = 0;

    int          n_vec = 0;
    int          n_err = 0;
    int          we_seen;
    logic [31:0] wd_seen;
    logic [31:0] pc_seen;

    always #5 clk = ~clk;

    dm_access_arbiter dut (
        .clk    (clk),    .reset  (reset),
        .req0   (req0),   .req1   (req1),
        .we0    (we0),    .we1    (we1),
        .addr0  (addr0),  .addr1  (addr1),
        .wdata0 (wdata0), .wdata1 (wdata1),
        .be0    (be0),    .be1    (be1),
        .pc0    (pc0),    .pc1    (pc1),
        .ack0   (ack0),   .ack1   (ack1),
        .rdata0 (rdata0), .rdata1 (rdata1),
        .m_addr (m_addr), .m_wd   (m_wd),
        .m_we   (m_we),   .m_pc   (m_pc),
        .m_rd   (m_rd),   .busy   (busy)
    );

    assign m_rd = mem[m_addr[11:2]];

    always @(posedge clk) begin
        if (m_we) begin
            mem[m_addr[11:2]] <= m_wd;
            write_cnt <= write_cnt + 1;
        end else if (pre_en) begin
            mem[pre_idx] <= pre_val;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end else begin
            $display("ok   %s: %h", tag, obs);
        end
    endtask

    task automatic preload(input logic [9:0] idx, input logic [31:0] val);
        @(posedge clk); #1;
        pre_en = 1'b1; pre_idx = idx; pre_val = val;
        @(posedge clk); #1;
        pre_en = 1'b0;
    endtask

    // Entered at posedge+1 with the DUT idle; returns at posedge+1 back in IDLE with req dropped.
    task automatic do_txn(input logic port, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be,
                          input int exp_lat, input logic [31:0] exp_rd, input string tag);
        int          lat;
        logic        other;
        logic [31:0] rd;
        lat = -1; other = 1'b0; rd = '0; we_seen = 0; wd_seen = '0; pc_seen = '0;
        if (port) begin
            we1 = we; addr1 = addr; wdata1 = wdata; be1 = be; req1 = 1'b1;
        end else begin
            we0 = we; addr0 = addr; wdata0 = wdata; be0 = be; req0 = 1'b1;
        end
        for (int k = 0; k < 10 && lat < 0; k++) begin
            @(negedge clk);
            if (m_we) begin
                we_seen++; wd_seen = m_wd; pc_seen = m_pc;
            end
            if (port ? ack0 : ack1) other = 1'b1;
            if (port ? ack1 : ack0) begin
                lat = k; rd = port ? rdata1 : rdata0;
            end
        end
        check({tag, " latency"}, lat, exp_lat);
        check({tag, " rdata"}, rd, exp_rd);
        check({tag, " other ack"}, {31'd0, other}, 32'd0);
        @(posedge clk); #1;
        req0 = 1'b0; req1 = 1'b0;
    endtask

    initial begin
        int          w0;
        int          ack_cnt;
        int          first_k;
        int          second_k;
        logic        grant_ids [4];
        logic        exp_ids   [4];
        logic [31:0] grant_rd  [4];

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst ack0", {31'd0, ack0}, 32'd0);
        check("rst ack1", {31'd0, ack1}, 32'd0);
        check("rst rdata0", rdata0, 32'd0);
        check("rst rdata1", rdata1, 32'd0);
        check("rst m_we", {31'd0, m_we}, 32'd0);
        check("rst m_addr", m_addr, 32'd0);
        check("rst m_wd", m_wd, 32'd0);
        check("rst m_pc", m_pc, 32'd0);
        check("rst busy", {31'd0, busy}, 32'd0);
        reset = 1'b1;

        // 1: plain load
        preload(10'd5, 32'hDEADBEEF);
        w0 = write_cnt;
        do_txn(1'b0, 1'b0, 32'h14, 32'h0, 4'hF, 2, 32'hDEADBEEF, "t1 load");
        check("t1 no write", write_cnt - w0, 32'd0);
        check("t1 rdata0 held", rdata0, 32'hDEADBEEF);
        check("t1 busy idle", {31'd0, busy}, 32'd0);

        // 2: single byte store from the bridge
        preload(10'd5, 32'h11223344);
        w0 = write_cnt;
        do_txn(1'b1, 1'b1, 32'h14, 32'h0000AA00, 4'b0010, 3, 32'h1122AA44, "t2 store");
        check("t2 write pulses", we_seen, 32'd1);
        check("t2 m_wd", wd_seen, 32'h1122AA44);
        check("t2 m_pc", pc_seen, 32'h0000_2000);
        check("t2 mem", mem[5], 32'h1122AA44);
        check("t2 write count", write_cnt - w0, 32'd1);

        // 3: contention, both requests held for four transactions
        preload(10'd10, 32'hA0A0A0A0);
        preload(10'd11, 32'hB1B1B1B1);
`ifdef DM_ARB_ROUND_ROBIN_EN
        exp_ids = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
        exp_ids = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
        we0 = 1'b0; addr0 = 32'h28; we1 = 1'b0; addr1 = 32'h2C;
        req0 = 1'b1; req1 = 1'b1;
        ack_cnt = 0;
        for (int k = 0; k < 40 && ack_cnt < 4; k++) begin
            @(negedge clk);
            if (ack0 || ack1) begin
                grant_ids[ack_cnt] = ack1;
                grant_rd[ack_cnt]  = ack1 ? rdata1 : rdata0;
                ack_cnt++;
            end
        end
        check("t3 ack count", ack_cnt, 32'd4);
        for (int i = 0; i < 4 && i < ack_cnt; i++) begin
            check($sformatf("t3 grant %0d", i), {31'd0, grant_ids[i]}, {31'd0, exp_ids[i]});
            check($sformatf("t3 rdata %0d", i), grant_rd[i], exp_ids[i] ? 32'hB1B1B1B1 : 32'hA0A0A0A0);
        end
        @(posedge clk); #1;
        req0 = 1'b0; req1 = 1'b0;

        // 4: store with no byte enables completes without a write
        w0 = write_cnt;
        do_txn(1'b0, 1'b1, 32'h14, 32'hFFFFFFFF, 4'b0000, 2, 32'h1122AA44, "t4 be0 store");
        check("t4 write pulses", we_seen, 32'd0);
        check("t4 mem", mem[5], 32'h1122AA44);

        // 5: reset while in WRITE aborts the transaction
        preload(10'd8, 32'h0);
        w0 = write_cnt;
        we0 = 1'b1; addr0 = 32'h20; wdata0 = 32'hCAFEF00D; be0 = 4'hF; req0 = 1'b1;
        repeat (3) @(negedge clk);
        check("t5 in write", {31'd0, m_we}, 32'd1);
        reset = 1'b0;
        #1;
        check("t5 m_we after rst", {31'd0, m_we}, 32'd0);
        check("t5 busy after rst", {31'd0, busy}, 32'd0);
        check("t5 ack0 after rst", {31'd0, ack0}, 32'd0);
        req0 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        check("t5 mem untouched", mem[8], 32'h0);
        check("t5 no write", write_cnt - w0, 32'd0);
        @(posedge clk); #1;
        do_txn(1'b0, 1'b1, 32'h20, 32'hCAFEF00D, 4'hF, 3, 32'hCAFEF00D, "t5 reissue");
        check("t5 mem written", mem[8], 32'hCAFEF00D);

        // 6: back-to-back loads with req0 held through the first ack
        we0 = 1'b0; addr0 = 32'h14; req0 = 1'b1;
        first_k = -1; second_k = -1;
        for (int k = 0; k < 20 && second_k < 0; k++) begin
            @(negedge clk);
            if (ack0) begin
                if (first_k < 0) first_k = k;
                else second_k = k;
            end
        end
        check("t6 first ack", first_k, 32'd2);
        check("t6 second ack", second_k, 32'd5);
        check("t6 rdata0", rdata0, 32'h1122AA44);
        @(posedge clk); #1;
        req0 = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
